// File: rtl/scmp_membus_pkg.sv
// Shared types and constants for the SC/MP strobe-bus to synchronous RAM bridge.
package scmp_membus_pkg;

    localparam int         SYNC_DEPTH   = 2;
    localparam logic [7:0] IDLE_VAL_DEF = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_ADDR   = 3'd1,
        ST_RD_DATA   = 3'd2,
        ST_RD_HOLD   = 3'd3,
        ST_WR_COMMIT = 3'd4
    } membus_state_t;

    // Saturating 8-bit increment used by the write-protect hit counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/scmp_strobe_sync.sv
// Synchroniser for one active-low CPU strobe, with fall/rise pulses taken from
// the synchronised copy. Strobes idle high, so every flop resets to 1.
module scmp_strobe_sync
    import scmp_membus_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n,
    output logic level_n,
    output logic fall,
    output logic rise
);

    logic [SYNC_DEPTH-1:0] sync_r;
    logic                  prev_r;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_DEPTH{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], strobe_n};
            prev_r <= sync_r[SYNC_DEPTH-1];
        end
    end

    assign level_n = sync_r[SYNC_DEPTH-1];
    assign fall    = prev_r & ~sync_r[SYNC_DEPTH-1];
    assign rise    = ~prev_r & sync_r[SYNC_DEPTH-1];

endmodule

// File: rtl/scmp_membus.sv
// SC/MP strobe bus to synchronous single-port RAM bridge.
// Optional write protection of the low RAM region: define SCMP_MEMBUS_WP_EN.
module scmp_membus
    import scmp_membus_pkg::*;
#(
    parameter int         ADDR_W   = 12,
    parameter int         MEM_AW   = 6,
    parameter logic [7:0] IDLE_VAL = IDLE_VAL_DEF,
    parameter int         WP_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_d_o,
    input  logic              cpu_ads_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    output logic [7:0]        cpu_d_i,
    output logic [MEM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [3:0]        flags,
    output logic              bus_err,
    output logic [7:0]        wp_hits
);

    membus_state_t     state_r;
    logic              ads_lvl_s, ads_fall_s, ads_rise_s;
    logic              rd_lvl_s, rd_fall_s, rd_rise_s;
    logic              wr_lvl_s, wr_fall_s, wr_rise_s;
    logic [MEM_AW-1:0] fold_addr_s;
    logic              wr_go_s;
    logic              wr_block_s;
    logic              unused_s;

    scmp_strobe_sync u_ads_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe_n (cpu_ads_n),
        .level_n  (ads_lvl_s),
        .fall     (ads_fall_s),
        .rise     (ads_rise_s)
    );

    scmp_strobe_sync u_rd_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe_n (cpu_rd_n),
        .level_n  (rd_lvl_s),
        .fall     (rd_fall_s),
        .rise     (rd_rise_s)
    );

    scmp_strobe_sync u_wr_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe_n (cpu_wr_n),
        .level_n  (wr_lvl_s),
        .fall     (wr_fall_s),
        .rise     (wr_rise_s)
    );

    // Upper address bits are ignored: the RAM image repeats every 2**MEM_AW bytes.
    assign fold_addr_s = cpu_addr[MEM_AW-1:0];
    assign wr_go_s     = wr_fall_s & ~ads_fall_s;
    assign unused_s    = ^{ads_lvl_s, ads_rise_s, rd_rise_s, wr_rise_s,
                           cpu_addr[ADDR_W-1:MEM_AW]};

`ifdef SCMP_MEMBUS_WP_EN
    localparam logic [MEM_AW-1:0] WP_LIM_C = MEM_AW'(WP_LIMIT);

    // Writes below the protection limit are suppressed.
    always_comb begin
        wr_block_s = 1'b0;
        if (fold_addr_s < WP_LIM_C) begin
            wr_block_s = 1'b1;
        end else begin
            wr_block_s = 1'b0;
        end
    end

    // Count suppressed writes, saturating at 8'hFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_hits <= 8'h00;
        end else if (wr_go_s && wr_block_s) begin
            wp_hits <= sat_inc8(wp_hits);
        end else begin
            wp_hits <= wp_hits;
        end
    end
`else
    localparam int unused_wp_limit_c = WP_LIMIT;

    assign wr_block_s = 1'b0;
    assign wp_hits    = 8'h00;
`endif

    // Bus FSM: address strobe aborts everything, a write strobe beats a read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cpu_d_i   <= IDLE_VAL;
            ram_addr  <= {MEM_AW{1'b0}};
            ram_we    <= 1'b0;
            ram_wdata <= 8'h00;
            flags     <= 4'h0;
        end else begin
            ram_we <= 1'b0;
            if (ads_fall_s) begin
                ram_addr <= fold_addr_s;
                flags    <= cpu_d_o[7:4];
                cpu_d_i  <= IDLE_VAL;
                state_r  <= ST_IDLE;
            end else if (wr_go_s) begin
                ram_addr  <= fold_addr_s;
                ram_wdata <= cpu_d_o;
                ram_we    <= ~wr_block_s;
                cpu_d_i   <= IDLE_VAL;
                state_r   <= ST_WR_COMMIT;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (rd_fall_s) begin
                            ram_addr <= fold_addr_s;
                            state_r  <= ST_RD_ADDR;
                        end else begin
                            state_r  <= ST_IDLE;
                        end
                    end
                    ST_RD_ADDR: begin
                        if (rd_lvl_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (rd_lvl_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            cpu_d_i <= ram_rdata;
                            state_r <= ST_RD_HOLD;
                        end
                    end
                    ST_RD_HOLD: begin
                        if (rd_lvl_s) begin
                            cpu_d_i <= IDLE_VAL;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_RD_HOLD;
                        end
                    end
                    ST_WR_COMMIT: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        cpu_d_i <= IDLE_VAL;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky collision flag: both data strobes low in the same synced cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_err <= 1'b0;
        end else if (!rd_lvl_s && !wr_lvl_s) begin
            bus_err <= 1'b1;
        end else begin
            bus_err <= bus_err;
        end
    end

endmodule
